// File: rtl/sat_addsub_pipe.sv
// sat_addsub_pipe: pipelined saturating signed adder/subtractor.
// The WIDTH-bit carry chain is split into STAGES registered segments of
// WIDTH/STAGES bits each. Packed mode (op[1]) cuts carries at every LANE_W
// boundary and saturates each lane on its own.
// Legal configurations: STAGES in {1,2,4}, LANE_W divides WIDTH and
// WIDTH/STAGES is a multiple of LANE_W, so every segment starts on a lane LSB.
//
// Handshake: a beat moves on an edge where valid & ready are both high.
// Input beats are accepted when in_valid & in_ready. A result is consumed
// when out_valid & out_ready. While out_valid & !out_ready, sum, the flags
// and out_valid hold steady. in_ready is combinational from out_ready.
//
// Optional macro SAT_ADDSUB_STICKY_OVF_EN adds ovf_clr / ovf_sticky: a sticky
// overflow bit set by any consumed result with flag_v=1 and cleared by
// ovf_clr. If set and clear happen in the same cycle, set wins.
module sat_addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int LANE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v
`ifdef SAT_ADDSUB_STICKY_OVF_EN
  ,
  input  logic             ovf_clr,
  output logic             ovf_sticky
`endif
);

  localparam int SEG_W  = WIDTH / STAGES;
  localparam int NLANES = WIDTH / LANE_W;

  // Per-stage beat state. Entries 0..STAGES-2 hold partially added beats:
  // operand A, effective B (already inverted for subtract), the result bits
  // finished so far, the carry out of the last finished segment, and the
  // mode bits. The last stage is the output register (sum and flags).
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] pk_q, pk_d;
  logic [STAGES-1:0] sub_q, sub_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  bx_q [STAGES];
  logic [WIDTH-1:0]  bx_d [STAGES];
  logic [WIDTH-1:0]  r_q [STAGES];
  logic [WIDTH-1:0]  r_d [STAGES];

  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              fn_q, fn_d;
  logic              fz_q, fz_d;
  logic              fv_q, fv_d;

  // What each stage would load this cycle: stage 0 takes the input port,
  // stage s takes the contents of stage s-1.
  logic [STAGES-1:0] src_v, src_c, src_pk, src_sub;
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_r [STAGES];
  logic [WIDTH:0]    seg_res [STAGES];
  logic [WIDTH:0]    sat_res;

  // adv[s]: stage s may load this cycle (empty, or its contents move on).
  logic [STAGES-1:0] adv;

  // Ripple-add the bits of segment seg. In packed mode every lane LSB gets
  // the subtract carry-in instead of the running carry, so no carry ever
  // crosses a lane boundary. Returns {carry_out, updated_result}.
  function automatic logic [WIDTH:0] add_seg(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic [WIDTH-1:0] r,
    input logic             cin,
    input logic             pk,
    input logic             sub,
    input int               seg
  );
    logic [WIDTH-1:0] res;
    logic             c;
    logic             ci;
    res = r;
    c   = cin;
    ci  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= seg * SEG_W && i < (seg + 1) * SEG_W) begin
        ci     = (pk && (i % LANE_W == 0)) ? sub : c;
        res[i] = x[i] ^ y[i] ^ ci;
        c      = (x[i] & y[i]) | (ci & (x[i] ^ y[i]));
      end
    end
    return {c, res};
  endfunction

  // Clamp a raw result. Overflow when A and effective B share a sign and
  // the raw result sign differs; clamp toward A's sign. Returns {v, sat}.
  function automatic logic [WIDTH:0] saturate(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic [WIDTH-1:0] r,
    input logic             pk
  );
    logic [WIDTH-1:0] res;
    logic             v;
    int               msb;
    res = r;
    v   = 1'b0;
    msb = 0;
    if (pk) begin
      for (int l = 0; l < NLANES; l++) begin
        msb = l * LANE_W + LANE_W - 1;
        if ((x[msb] == y[msb]) && (r[msb] != x[msb])) begin
          v = 1'b1;
          for (int k = 0; k < LANE_W; k++) begin
            res[l * LANE_W + k] = (k == LANE_W - 1) ? x[msb] : ~x[msb];
          end
        end
      end
    end else begin
      if ((x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1])) begin
        v = 1'b1;
        for (int k = 0; k < WIDTH; k++) begin
          res[k] = (k == WIDTH - 1) ? x[WIDTH-1] : ~x[WIDTH-1];
        end
      end
    end
    return {v, res};
  endfunction

  // Backpressure chain: stage s advances unless it and every stage after it
  // are full while the consumer is stalling.
  always_comb begin
    logic all_v;
    all_v = 1'b1;
    adv   = '0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      all_v  = all_v & v_q[s];
      adv[s] = out_ready | ~all_v;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[STAGES-1];
  assign sum       = sum_q;
  assign flag_n    = fn_q;
  assign flag_z    = fz_q;
  assign flag_v    = fv_q;

  // Datapath next state: add one segment per stage, saturate in the last.
  always_comb begin
    v_d     = v_q;
    c_d     = c_q;
    pk_d    = pk_q;
    sub_d   = sub_q;
    sum_d   = sum_q;
    fn_d    = fn_q;
    fz_d    = fz_q;
    fv_d    = fv_q;
    sat_res = '0;
    src_v   = '0;
    src_c   = '0;
    src_pk  = '0;
    src_sub = '0;
    for (int s = 0; s < STAGES; s++) begin
      a_d[s]     = a_q[s];
      bx_d[s]    = bx_q[s];
      r_d[s]     = r_q[s];
      src_a[s]   = '0;
      src_b[s]   = '0;
      src_r[s]   = '0;
      seg_res[s] = '0;
    end

    src_v[0]   = in_valid;
    src_a[0]   = a;
    src_b[0]   = op[0] ? ~b : b;
    src_r[0]   = '0;
    src_c[0]   = op[0];
    src_pk[0]  = op[1];
    src_sub[0] = op[0];
    for (int s = 1; s < STAGES; s++) begin
      src_v[s]   = v_q[s-1];
      src_a[s]   = a_q[s-1];
      src_b[s]   = bx_q[s-1];
      src_r[s]   = r_q[s-1];
      src_c[s]   = c_q[s-1];
      src_pk[s]  = pk_q[s-1];
      src_sub[s] = sub_q[s-1];
    end

    for (int s = 0; s < STAGES; s++) begin
      seg_res[s] = add_seg(src_a[s], src_b[s], src_r[s], src_c[s],
                           src_pk[s], src_sub[s], s);
      if (adv[s]) begin
        v_d[s] = src_v[s];
        if (src_v[s]) begin
          if (s == STAGES - 1) begin
            sat_res = saturate(src_a[s], src_b[s], seg_res[s][WIDTH-1:0], src_pk[s]);
            sum_d   = sat_res[WIDTH-1:0];
            fv_d    = sat_res[WIDTH];
            fn_d    = sat_res[WIDTH-1];
            fz_d    = (sat_res[WIDTH-1:0] == '0);
          end else begin
            a_d[s]   = src_a[s];
            bx_d[s]  = src_b[s];
            r_d[s]   = seg_res[s][WIDTH-1:0];
            c_d[s]   = seg_res[s][WIDTH];
            pk_d[s]  = src_pk[s];
            sub_d[s] = src_sub[s];
          end
        end
      end
    end
  end

  // Pipeline registers; reset drops every in-flight beat at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      pk_q  <= '0;
      sub_q <= '0;
      sum_q <= '0;
      fn_q  <= 1'b0;
      fz_q  <= 1'b0;
      fv_q  <= 1'b0;
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]  <= '0;
        bx_q[s] <= '0;
        r_q[s]  <= '0;
      end
    end else begin
      v_q   <= v_d;
      c_q   <= c_d;
      pk_q  <= pk_d;
      sub_q <= sub_d;
      sum_q <= sum_d;
      fn_q  <= fn_d;
      fz_q  <= fz_d;
      fv_q  <= fv_d;
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]  <= a_d[s];
        bx_q[s] <= bx_d[s];
        r_q[s]  <= r_d[s];
      end
    end
  end

`ifdef SAT_ADDSUB_STICKY_OVF_EN
  logic ovf_sticky_q, ovf_sticky_d;

  // Sticky overflow: clear first so a same-cycle set overrides it.
  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    if (ovf_clr) begin
      ovf_sticky_d = 1'b0;
    end
    if (out_valid && out_ready && fv_q) begin
      ovf_sticky_d = 1'b1;
    end
  end

  // Sticky overflow register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky_q <= 1'b0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign ovf_sticky = ovf_sticky_q;
`endif

endmodule

// File: doc/sat_addsub_pipe.md
Name: sat_addsub_pipe

Overview:
- Parametrised, pipelined, saturating signed adder/subtractor for the datapath ALU.
- Splits the WIDTH-bit carry chain across STAGES registered segments.
- Supports a packed mode that cuts carries at LANE_W boundaries and saturates each lane independently (PADDSB-style).
- Valid/ready handshake on both sides, so the ALU can stall it. Produces N/Z/V flags for the flag register.

Parameters:
- WIDTH, 16, operand/result width in bits.
- STAGES, 2, pipeline depth/latency; legal values 1, 2, 4; WIDTH/STAGES must be a multiple of LANE_W.
- LANE_W, 4, lane width in packed mode; must divide WIDTH.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A, two's complement.
- b  in  WIDTH  operand B, two's complement.
- op  in  2  bit0 = subtract (A-B), bit1 = packed lane mode.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  saturated result.
- flag_n  out  1  sum[WIDTH-1].
- flag_z  out  1  sum == 0.
- flag_v  out  1  overflow occurred before saturation (packed mode: OR over lanes).

Behaviour:
- Reset (async, immediate): all stage valid bits 0, out_valid=0, sum=0, flags=0, in_ready=1. An in-flight beat is discarded and no partial result is ever presented.
- Subtract: B is inverted and carry-in is 1 into bit 0. In packed mode, carry-in is 1 into every lane LSB. Add uses carry-in 0.
- Segment s (0..STAGES-1) computes bits [(s+1)*C-1 : s*C], where C = WIDTH/STAGES.
  - The carry into segment s is registered from segment s-1.
  - In packed mode, carries never cross a lane boundary, so the segment carry-in is the lane carry-in.
  - Not-yet-added operand bits, op, and the operand sign bits travel with the beat.
- Overflow per word or lane: the sign of A equals the sign of effective B, and the result sign differs from it.
  - Positive overflow (A sign 0) -> 0111...1.
  - Negative overflow (A sign 1) -> 1000...0.
  - Otherwise the raw result is passed through.
  - Saturation and flags are computed from final-stage state and registered with sum.
- Latency: exactly STAGES cycles from accepted beat (in_valid & in_ready) to out_valid when unstalled. Throughput is 1 beat per cycle.
- Flow control:
  - Stage i advances when it is empty or stage i+1 advances; the output stage advances when !out_valid or out_ready.
  - in_ready = first stage empty or first stage advancing (combinational from out_ready through the chain).
  - sum, flags and out_valid hold stable while out_valid & !out_ready.
  - No beat is lost or duplicated, and order is preserved.
  - Simultaneous accept and emit in the same cycle is legal at full pipe.
- STAGES=1: purely one register stage; same handshake rules.
- in_valid with in_ready=0 is ignored; a, b and op are sampled only on accept.

Optional Feature:
- Macro SAT_ADDSUB_STICKY_OVF_EN adds ports ovf_clr (in, 1) and ovf_sticky (out, 1).
- ovf_sticky is set on any emitted beat (out_valid & out_ready) with flag_v=1.
- ovf_sticky is cleared by ovf_clr; if set and clear occur in the same cycle, set wins. Reset value is 0.
- Without the macro, these ports and the register do not exist and behaviour is otherwise identical.

Test Plan:
- WIDTH=16, STAGES=2, out_ready=1, op=00, a=0x7FFF, b=0x0001 -> 2 cycles later sum=0x7FFF, V=1, N=0, Z=0.
- op=01, a=0x8000, b=0x0001 -> sum=0x8000, V=1, N=1; then a=0x1234, b=0x1234 -> sum=0x0000, Z=1, V=0.
- op=10, a=0x7F08, b=0x1188 -> sum=0x7088, V=1, with lanes 7+1 saturating to 7 and -8+-8 saturating to 8. Also op=11, a=0x8000, b=0x1000 -> sum=0x8000, V=1.
- Backpressure: hold out_ready=0 and offer 4 back-to-back beats -> in_ready drops after STAGES beats accepted. Release out_ready -> all accepted results emerge in order, with no drops or duplicates and sum stable while stalled.
- Assert rst for 1 cycle mid-stream with 2 beats in flight -> out_valid=0 immediately, in_ready=1, and no stale result appears afterwards.
- With SAT_ADDSUB_STICKY_OVF_EN: an overflow beat sets ovf_sticky, a following clean beat leaves it set, and ovf_clr clears it. With overflow emit and ovf_clr in the same cycle, ovf_sticky stays 1.
